// File: rtl/risc_mon_pkg.sv
// Shared types and defaults for the KGP_RISC run controller / result monitor.
package risc_mon_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_RST_CYCLES  = 3;
  localparam int unsigned DEF_TIMEOUT     = 200;
  localparam int unsigned DEF_HALT_REPEAT = 8;
  localparam int unsigned DEF_TRACE_DEPTH = 16;

  function automatic int unsigned trace_entry_w(input int unsigned pc_w, input int unsigned data_w);
    return pc_w + data_w;
  endfunction

endpackage

// File: rtl/risc_mon_trace_fifo.sv
// First-word-fall-through trace FIFO with occupancy count and sticky overflow.
module risc_mon_trace_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot in the same edge, so a write while full still lands.
  assign do_rd = rd_en && !empty && !clr;
  assign do_wr = wr_en && (!full || do_rd) && !clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      if (wr_en && !do_wr) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/risc_run_monitor.sv
// Run controller and result-change trace monitor for the KGP_RISC core.
// Optional result signature enabled by defining RISC_MON_SIGNATURE_EN.
module risc_run_monitor
  import risc_mon_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
  parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      restart,
  output logic                                      core_rst,
  input  logic [DATA_W-1:0]                         res_in,
  input  logic [PC_W-1:0]                           pc_in,
  input  logic                                      trace_rd_en,
  output logic [trace_entry_w(PC_W, DATA_W)-1:0]    trace_rd_data,
  output logic                                      trace_empty,
  output logic [$clog2(TRACE_DEPTH):0]              trace_count,
  output logic                                      trace_overflow,
  output logic                                      run_done,
  output logic                                      halted,
  output logic                                      timed_out,
  output logic [31:0]                               cycle_count,
  output logic [DATA_W-1:0]                         signature
);

  localparam int unsigned HCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned SCW = $clog2(HALT_REPEAT);

  mon_state_e        state_q, state_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [SCW-1:0]    pc_stable_q, pc_stable_d;
  logic [DATA_W-1:0] prev_res_q;
  logic [PC_W-1:0]   prev_pc_q;
  logic              halted_q, halted_d, timed_out_q, timed_out_d;
  logic              trace_wr, pc_same;

  assign pc_same = (pc_in == prev_pc_q);

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    pc_stable_d   = pc_stable_q;
    halted_d      = halted_q;
    timed_out_d   = timed_out_q;
    trace_wr      = 1'b0;
    if (restart) begin
      state_d       = ST_HOLD;
      hold_cnt_d    = '0;
      cycle_count_d = '0;
      pc_stable_d   = '0;
      halted_d      = 1'b0;
      timed_out_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HCW'(RST_CYCLES - 1)) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end
        ST_RUN: begin
          // cycle_count is still 0 only in the first RUN cycle of a run.
          trace_wr      = (cycle_count_q == '0) || (res_in != prev_res_q);
          cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 32'd1;
          pc_stable_d   = pc_same ? pc_stable_q + SCW'(1) : '0;
          if (pc_same && (pc_stable_q == SCW'(HALT_REPEAT - 2))) begin
            halted_d = 1'b1;
            state_d  = ST_DONE;
          end
          if (cycle_count_d == 32'(TIMEOUT)) begin
            timed_out_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      pc_stable_q   <= '0;
      halted_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      prev_res_q    <= '0;
      prev_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      pc_stable_q   <= pc_stable_d;
      halted_q      <= halted_d;
      timed_out_q   <= timed_out_d;
      prev_res_q    <= res_in;
      prev_pc_q     <= pc_in;
    end
  end

`ifdef RISC_MON_SIGNATURE_EN
  logic [DATA_W-1:0] signature_q, signature_d;

  always_comb begin
    signature_d = signature_q;
    if (restart)
      signature_d = '0;
    else if (trace_wr)
      signature_d = {signature_q[DATA_W-2:0], signature_q[DATA_W-1]} ^ res_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) signature_q <= '0;
    else     signature_q <= signature_d;
  end

  assign signature = signature_q;
`else
  assign signature = '0;
`endif

  risc_mon_trace_fifo #(
    .WIDTH (trace_entry_w(PC_W, DATA_W)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (CLK),
    .rst      (RST),
    .clr      (restart),
    .wr_en    (trace_wr),
    .wr_data  ({pc_in, res_in}),
    .rd_en    (trace_rd_en),
    .rd_data  (trace_rd_data),
    .empty    (trace_empty),
    .count    (trace_count),
    .overflow (trace_overflow)
  );

  assign core_rst    = (state_q != ST_RUN);
  assign run_done    = (state_q == ST_DONE);
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_risc_run_monitor.sv
// Directed self-checking bench for risc_run_monitor (TRACE_DEPTH=4 instance).
module tb_risc_run_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        restart;
  logic        core_rst;
  logic [31:0] res_in;
  logic [31:0] pc_in;
  logic        trace_rd_en;
  logic [63:0] trace_rd_data;
  logic        trace_empty;
  logic [2:0]  trace_count;
  logic        trace_overflow;
  logic        run_done;
  logic        halted;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic [31:0] signature;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  risc_run_monitor #(
    .DATA_W      (32),
    .PC_W        (32),
    .RST_CYCLES  (3),
    .TIMEOUT     (200),
    .HALT_REPEAT (8),
    .TRACE_DEPTH (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .restart        (restart),
    .core_rst       (core_rst),
    .res_in         (res_in),
    .pc_in          (pc_in),
    .trace_rd_en    (trace_rd_en),
    .trace_rd_data  (trace_rd_data),
    .trace_empty    (trace_empty),
    .trace_count    (trace_count),
    .trace_overflow (trace_overflow),
    .run_done       (run_done),
    .halted         (halted),
    .timed_out      (timed_out),
    .cycle_count    (cycle_count),
    .signature      (signature)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse restart and walk through the 3 hold edges into RUN cycle 0.
  task automatic restart_and_hold();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic exp_rst;
    repeat (3) tick();
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    n_cmp++; if (trace_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", trace_empty); end
    n_cmp++; if (trace_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", trace_count); end
    n_cmp++; if (trace_rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", trace_rd_data); end
    n_cmp++; if (run_done !== 1'b0) begin n_fail++; $display("FAIL reset_run_done: got %b want 0", run_done); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
    n_cmp++; if (signature !== 32'd0) begin n_fail++; $display("FAIL reset_signature: got %h want 0", signature); end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_rst = (i < 2);
      n_cmp++; if (core_rst !== exp_rst) begin n_fail++; $display("FAIL hold_core_rst[%0d]: got %b want %b", i, core_rst, exp_rst); end
    end
  endtask

  task automatic test_change_log();
    logic [31:0] rv [5] = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd9};
    logic [31:0] pv [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
    logic [63:0] ev [3] = '{{32'd0, 32'd5}, {32'd8, 32'd7}, {32'd16, 32'd9}};
    logic [31:0] exp_sig;
`ifdef RISC_MON_SIGNATURE_EN
    exp_sig = 32'd19;
`else
    exp_sig = 32'd0;
`endif
    for (int i = 0; i < 5; i++) begin
      res_in = rv[i];
      pc_in  = pv[i];
      tick();
    end
    n_cmp++; if (trace_count !== 3'd3) begin n_fail++; $display("FAIL log_count: got %0d want 3", trace_count); end
    n_cmp++; if (cycle_count !== 32'd5) begin n_fail++; $display("FAIL log_cycle_count: got %0d want 5", cycle_count); end
    n_cmp++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL log_core_rst: got %b want 0", core_rst); end
    n_cmp++; if (signature !== exp_sig) begin n_fail++; $display("FAIL log_signature: got %h want %h", signature, exp_sig); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (trace_rd_data !== ev[i]) begin n_fail++; $display("FAIL log_entry[%0d]: got %h want %h", i, trace_rd_data, ev[i]); end
      trace_rd_en = 1'b1;
      pc_in = pc_in + 32'd4;
      tick();
    end
    trace_rd_en = 1'b0;
    n_cmp++; if (trace_empty !== 1'b1) begin n_fail++; $display("FAIL log_drained_empty: got %b want 1", trace_empty); end
    n_cmp++; if (trace_rd_data !== 64'd0) begin n_fail++; $display("FAIL log_drained_data: got %h want 0", trace_rd_data); end
  endtask

  task automatic test_halt();
    logic exp_done;
    pc_in  = 32'd0;
    res_in = 32'h33;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL halt_restart_core_rst: got %b want 1", core_rst); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL halt_restart_cycles: got %0d want 0", cycle_count); end
    repeat (3) tick();
    for (int k = 0; k < 18; k++) begin
      pc_in = (k < 10) ? 32'h100 + 32'(4 * k) : 32'h40;
      tick();
      exp_done = (k == 17);
      n_cmp++; if (run_done !== exp_done) begin n_fail++; $display("FAIL halt_run_done[%0d]: got %b want %b", k, run_done, exp_done); end
    end
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b want 1", halted); end
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL halt_timed_out: got %b want 0", timed_out); end
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL halt_core_rst: got %b want 1", core_rst); end
    n_cmp++; if (cycle_count !== 32'd18) begin n_fail++; $display("FAIL halt_cycle_count: got %0d want 18", cycle_count); end
    repeat (3) tick();
    n_cmp++; if (cycle_count !== 32'd18) begin n_fail++; $display("FAIL halt_frozen_cycles: got %0d want 18", cycle_count); end
    n_cmp++; if (run_done !== 1'b1) begin n_fail++; $display("FAIL halt_done_held: got %b want 1", run_done); end
  endtask

  task automatic test_timeout();
    pc_in  = 32'd0;
    res_in = 32'h77;
    restart_and_hold();
    for (int k = 0; k < 200; k++) begin
      pc_in = 32'(4 * k + 4);
      tick();
      if (k == 198) begin
        n_cmp++; if (run_done !== 1'b0) begin n_fail++; $display("FAIL to_early_done: got %b want 0", run_done); end
        n_cmp++; if (cycle_count !== 32'd199) begin n_fail++; $display("FAIL to_cycles_199: got %0d want 199", cycle_count); end
      end
    end
    n_cmp++; if (timed_out !== 1'b1) begin n_fail++; $display("FAIL to_timed_out: got %b want 1", timed_out); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL to_halted: got %b want 0", halted); end
    n_cmp++; if (run_done !== 1'b1) begin n_fail++; $display("FAIL to_run_done: got %b want 1", run_done); end
    n_cmp++; if (cycle_count !== 32'd200) begin n_fail++; $display("FAIL to_cycle_count: got %0d want 200", cycle_count); end
  endtask

  task automatic test_overflow_wrap();
    logic [63:0] exp_e;
    pc_in  = 32'd0;
    res_in = 32'd0;
    restart_and_hold();
    n_cmp++; if (trace_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", trace_overflow); end
    for (int k = 0; k < 6; k++) begin
      res_in = 32'hA0 + 32'(k);
      pc_in  = 32'(16 * (k + 1));
      tick();
    end
    n_cmp++; if (trace_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", trace_count); end
    n_cmp++; if (trace_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", trace_overflow); end
    for (int i = 0; i < 4; i++) begin
      exp_e = {32'(16 * (i + 1)), 32'hA0 + 32'(i)};
      n_cmp++; if (trace_rd_data !== exp_e) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, trace_rd_data, exp_e); end
      trace_rd_en = 1'b1;
      pc_in = pc_in + 32'd4;
      tick();
    end
    trace_rd_en = 1'b0;
    n_cmp++; if (trace_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b want 1", trace_empty); end
    for (int j = 0; j < 4; j++) begin
      res_in = 32'hB0 + 32'(j);
      pc_in  = 32'h200 + 32'(4 * j);
      tick();
    end
    n_cmp++; if (trace_count !== 3'd4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", trace_count); end
    for (int j = 0; j < 4; j++) begin
      exp_e = {32'h200 + 32'(4 * j), 32'hB0 + 32'(j)};
      n_cmp++; if (trace_rd_data !== exp_e) begin n_fail++; $display("FAIL wrap_entry[%0d]: got %h want %h", j, trace_rd_data, exp_e); end
      trace_rd_en = 1'b1;
      pc_in = pc_in + 32'd4;
      tick();
    end
    trace_rd_en = 1'b0;
    n_cmp++; if (trace_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", trace_empty); end
    n_cmp++; if (trace_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf_sticky: got %b want 1", trace_overflow); end
  endtask

  task automatic test_restart();
    logic exp_rst;
    pc_in  = 32'd0;
    res_in = 32'd0;
    restart_and_hold();
    for (int k = 0; k < 50; k++) begin
      res_in = 32'(k + 1);
      pc_in  = 32'(4 * k + 4);
      tick();
    end
    n_cmp++; if (cycle_count !== 32'd50) begin n_fail++; $display("FAIL rs_pre_cycles: got %0d want 50", cycle_count); end
    n_cmp++; if (trace_overflow !== 1'b1) begin n_fail++; $display("FAIL rs_pre_ovf: got %b want 1", trace_overflow); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++; if (trace_empty !== 1'b1) begin n_fail++; $display("FAIL rs_empty: got %b want 1", trace_empty); end
    n_cmp++; if (trace_count !== 3'd0) begin n_fail++; $display("FAIL rs_count: got %0d want 0", trace_count); end
    n_cmp++; if (trace_overflow !== 1'b0) begin n_fail++; $display("FAIL rs_ovf: got %b want 0", trace_overflow); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL rs_cycles: got %0d want 0", cycle_count); end
    n_cmp++; if ({halted, timed_out, run_done} !== 3'b000) begin n_fail++; $display("FAIL rs_flags: got %b want 000", {halted, timed_out, run_done}); end
    n_cmp++; if (signature !== 32'd0) begin n_fail++; $display("FAIL rs_signature: got %h want 0", signature); end
    n_cmp++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL rs_core_rst: got %b want 1", core_rst); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_rst = (i < 2);
      n_cmp++; if (core_rst !== exp_rst) begin n_fail++; $display("FAIL rs_hold[%0d]: got %b want %b", i, core_rst, exp_rst); end
    end
  endtask

  initial begin
    RST         = 1'b1;
    restart     = 1'b0;
    res_in      = '0;
    pc_in       = '0;
    trace_rd_en = 1'b0;
    test_reset();
    test_change_log();
    test_halt();
    test_timeout();
    test_overflow_wrap();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_run_monitor.md
# risc_run_monitor

Synthesizable run controller and result monitor for the KGP_RISC core. It sequences the core's reset, and it logs every change of the core's result bus, with the PC at that point, into a trace FIFO. It ends the run on halt detection or timeout. This generalises the fixed bench sequence (hold reset, release, watch resOut, stop after a fixed time) into a parametrised on-chip block that sits beside the `RISC` instance.

## Interface
Parameters:
- DATA_W, 32, width of the monitored result bus
- PC_W, 32, width of the monitored program counter
- RST_CYCLES, 3, number of cycles core_rst is held after reset or restart (≥1)
- TIMEOUT, 200, number of RUN cycles before a forced stop (≥1)
- HALT_REPEAT, 8, number of consecutive cycles with an unchanged PC that counts as a halt (≥2)
- TRACE_DEPTH, 16, number of trace FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  clock, single domain
- RST  in  1  asynchronous, active-high reset
- restart  in  1  single-cycle pulse that starts a new run
- core_rst  out  1  reset driven to the core
- res_in  in  DATA_W  core resOut
- pc_in  in  PC_W  core PC
- trace_rd_en  in  1  pops the FIFO head
- trace_rd_data  out  PC_W+DATA_W  FIFO head as {pc, res}, first-word fall-through
- trace_empty  out  1  FIFO empty
- trace_count  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy
- trace_overflow  out  1  sticky; at least one entry was dropped
- run_done  out  1  FSM is in DONE
- halted  out  1  sticky; the run ended on halt detection
- timed_out  out  1  sticky; the run ended on timeout
- cycle_count  out  32  number of RUN cycles elapsed
- signature  out  DATA_W  running result signature (see Configuration)

## Operation
- FSM states are HOLD, RUN and DONE.
- HOLD:
  - core_rst=1.
  - A hold counter counts RST_CYCLES cycles, then the FSM moves to RUN.
- RUN:
  - core_rst=0 and cycle_count increments every cycle.
  - A trace entry {pc_in, res_in} is written on the first RUN cycle and on every cycle where res_in differs from the res_in registered the cycle before.
  - A PC-stable counter increments when pc_in equals the previous pc_in and resets to 0 otherwise.
  - When the PC-stable counter reaches HALT_REPEAT-1, halted is set and the FSM moves to DONE.
  - When cycle_count reaches TIMEOUT, timed_out is set and the FSM moves to DONE.
  - If both conditions occur in the same cycle, both flags are set.
- DONE:
  - core_rst=1, freezing the core.
  - Counters hold their values.
  - The trace can still be read.
- restart, accepted in any state:
  - Moves the FSM to HOLD.
  - Clears the FIFO, overflow, halted, timed_out, cycle_count, the PC-stable counter and signature.
  - If restart arrives during HOLD, the hold count begins again.
- FIFO behaviour:
  - A write while full is dropped and sets trace_overflow.
  - A read while empty is ignored.
  - A simultaneous read and write while full accepts both; occupancy is unchanged and no overflow is flagged.
  - A simultaneous read and write while empty: the write lands and the read is ignored.
  - Pointers are log2(TRACE_DEPTH) bits wide and wrap naturally.
- cycle_count saturates at 2^32-1.
- Reset (RST high, asynchronous):
  - FSM=HOLD and hold counter=0.
  - core_rst=1.
  - FIFO empty, trace_empty=1, trace_count=0, trace_rd_data=0.
  - All flags, counters and signature are 0.
  - The previous-res register and previous-pc register are 0.
  - RST asserted mid-run aborts the run immediately.

## Timing
- core_rst is high throughout RST and for RST_CYCLES rising edges after RST deasserts; it falls in the cycle the FSM enters RUN.
- A trace write is registered at the edge where the change is seen. trace_empty falls and the entry is visible on trace_rd_data the following cycle.
- Pop: trace_rd_en sampled high at an edge advances the head; the new head is visible after that edge.
- run_done, halted and timed_out rise one cycle after the terminating condition is sampled.
- restart takes effect at the next edge; core_rst is already 1 in the cycle after restart.

## Configuration
- RISC_MON_SIGNATURE_EN defined:
  - On every trace write, signature <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ res_in.
  - The update happens even when the write is dropped on overflow.
- RISC_MON_SIGNATURE_EN undefined: signature is tied to 0 and no register is inferred.

## Structure
- Package risc_mon_pkg holds:
  - FSM state encodings (HOLD=2'd0, RUN=2'd1, DONE=2'd2).
  - The trace entry width helper.
  - The default parameter constants.
- Sub-module risc_mon_trace_fifo: a parametrised width × depth first-word-fall-through FIFO with count, full, empty and sticky overflow. It is instantiated once.

## Test plan
- Reset and hold: RST high for 3 cycles, then low, with RST_CYCLES=3 → core_rst high for 3 edges after release; run_done=0; trace_empty=1.
- Change logging: res_in sequence 5,5,7,7,9 with pc 0,4,8,12,16 → entries {0,5},{8,7},{16,9}; trace_count=3.
- Halt: pc_in held at 0x40 from RUN cycle 10, HALT_REPEAT=8 → halted=1 and run_done=1 at cycle 18; timed_out=0; core_rst=1.
- Timeout: TIMEOUT=200 with pc_in incrementing every cycle → timed_out=1; cycle_count=200.
- Overflow and wrap: TRACE_DEPTH=4, res_in changes every cycle for 6 cycles with no reads → count=4 and trace_overflow=1; drain 4 entries and log 4 more → correct order across the pointer wrap.
- Restart mid-run at cycle 50 → FIFO cleared, flags and cycle_count=0, core_rst high for RST_CYCLES; with the macro defined, signature=0.
